// File: rtl/input_conditioner.sv
// Player-input front end: merges PS/2 key events with MiSTer joystick words,
// cancels opposing directions and stretches coin presses into fixed pulses.
module input_conditioner #(
    parameter int COIN_CYCLES = 4800000
) (
    input  logic        clk_sys,
    input  logic        RESET,
    input  logic [10:0] ps2_key,
    input  logic [10:0] joystick_0,
    input  logic [10:0] joystick_1,
    output logic [3:0]  p1_dir,
    output logic [3:0]  p2_dir,
    output logic [2:0]  p1_buttons,
    output logic [2:0]  p2_buttons,
    output logic        p1_start,
    output logic        p2_start,
    output logic        p1_pause,
    output logic        p2_pause,
    output logic        p1_coin,
    output logic        p2_coin,
    output logic [1:0]  service
);

    localparam int CNT_W = 23;
    localparam logic [CNT_W-1:0] COIN_LOAD = CNT_W'(COIN_CYCLES - 1);

    // Control bit positions, shared by the joystick word and the key latches
    localparam int J_R     = 0;
    localparam int J_L     = 1;
    localparam int J_D     = 2;
    localparam int J_U     = 3;
    localparam int J_B1    = 4;
    localparam int J_B2    = 5;
    localparam int J_B3    = 6;
    localparam int J_START = 7;
    localparam int J_COIN  = 8;
    localparam int J_PAUSE = 9;

    typedef enum logic {
        COIN_IDLE  = 1'b0,
        COIN_PULSE = 1'b1
    } coin_state_t;

    // Input is {up, down, left, right}; a pressed opposing pair reads as neither.
    function automatic logic [3:0] cancel_opposing(input logic [3:0] udlr);
        logic [3:0] res;
        res = udlr;
        if (udlr[3] && udlr[2]) res[3:2] = 2'b00;
        if (udlr[1] && udlr[0]) res[1:0] = 2'b00;
        return res;
    endfunction

    logic        tog_q, tog_d;
    logic        primed_q, primed_d;
    logic        key_evt;
    logic [9:0]  p1_key_q, p1_key_d;
    logic [8:0]  p2_key_q, p2_key_d;
    logic [1:0]  svc_key_q, svc_key_d;
    logic [9:0]  joy0_q, joy0_d;
    logic [9:0]  joy1_q, joy1_d;

    logic [9:0]  p1_raw, p2_raw;
    logic [3:0]  p1_dir_q, p1_dir_d, p2_dir_q, p2_dir_d;
    logic [2:0]  p1_btn_q, p1_btn_d, p2_btn_q, p2_btn_d;
    logic        p1_start_q, p1_start_d, p2_start_q, p2_start_d;
    logic        p1_pause_q, p1_pause_d, p2_pause_q, p2_pause_d;
    logic [1:0]  service_q, service_d;
    logic [1:0]  coin_src_q, coin_src_d;
    logic [1:0]  coin_src_prev_q, coin_src_prev_d;

    coin_state_t          coin_state_q [2];
    coin_state_t          coin_state_d [2];
    logic [CNT_W-1:0]     coin_cnt_q   [2];
    logic [CNT_W-1:0]     coin_cnt_d   [2];

    logic unused_inputs;
    assign unused_inputs = ^{ps2_key[8], joystick_0[10], joystick_1[10]};

    // Stage 1: key event detect / latch and joystick capture
    always_comb begin
        tog_d     = ps2_key[10];
        primed_d  = 1'b1;
        key_evt   = primed_q && (ps2_key[10] != tog_q);
        p1_key_d  = p1_key_q;
        p2_key_d  = p2_key_q;
        svc_key_d = svc_key_q;
        joy0_d    = joystick_0[9:0];
        joy1_d    = joystick_1[9:0];
        if (key_evt) begin
            case (ps2_key[7:0])
                8'h75: p1_key_d[J_U]     = ps2_key[9];
                8'h72: p1_key_d[J_D]     = ps2_key[9];
                8'h6B: p1_key_d[J_L]     = ps2_key[9];
                8'h74: p1_key_d[J_R]     = ps2_key[9];
                8'h14: p1_key_d[J_B1]    = ps2_key[9];
                8'h11: p1_key_d[J_B2]    = ps2_key[9];
                8'h29: p1_key_d[J_B3]    = ps2_key[9];
                8'h16: p1_key_d[J_START] = ps2_key[9];
                8'h2E: p1_key_d[J_COIN]  = ps2_key[9];
                8'h4D: p1_key_d[J_PAUSE] = ps2_key[9];
                8'h2D: p2_key_d[J_U]     = ps2_key[9];
                8'h2B: p2_key_d[J_D]     = ps2_key[9];
                8'h23: p2_key_d[J_L]     = ps2_key[9];
                8'h34: p2_key_d[J_R]     = ps2_key[9];
                8'h1C: p2_key_d[J_B1]    = ps2_key[9];
                8'h1B: p2_key_d[J_B2]    = ps2_key[9];
                8'h15: p2_key_d[J_B3]    = ps2_key[9];
                8'h1E: p2_key_d[J_START] = ps2_key[9];
                8'h36: p2_key_d[J_COIN]  = ps2_key[9];
                8'h46: svc_key_d[0]      = ps2_key[9];
                8'h45: svc_key_d[1]      = ps2_key[9];
                default: ;
            endcase
        end
    end

    // Stage 2: combine keys with joystick and register every output
    always_comb begin
        p1_raw          = p1_key_q | joy0_q;
        p2_raw          = {joy1_q[J_PAUSE], p2_key_q | joy1_q[8:0]};
        p1_dir_d        = cancel_opposing(p1_raw[J_U:J_R]);
        p2_dir_d        = cancel_opposing(p2_raw[J_U:J_R]);
        p1_btn_d        = p1_raw[J_B3:J_B1];
        p2_btn_d        = p2_raw[J_B3:J_B1];
        p1_start_d      = p1_raw[J_START];
        p2_start_d      = p2_raw[J_START];
        p1_pause_d      = p1_raw[J_PAUSE];
        p2_pause_d      = p2_raw[J_PAUSE];
        service_d       = svc_key_q;
        coin_src_d      = {p2_raw[J_COIN], p1_raw[J_COIN]};
        coin_src_prev_d = coin_src_q;
    end

    // Stage 3: coin stretchers, one per player; only a rise seen in IDLE starts a pulse
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            coin_state_d[p] = coin_state_q[p];
            coin_cnt_d[p]   = coin_cnt_q[p];
            unique case (coin_state_q[p])
                COIN_IDLE: begin
                    if (coin_src_q[p] && !coin_src_prev_q[p]) begin
                        coin_state_d[p] = COIN_PULSE;
                        coin_cnt_d[p]   = COIN_LOAD;
                    end
                end
                COIN_PULSE: begin
                    if (coin_cnt_q[p] == '0) begin
                        coin_state_d[p] = COIN_IDLE;
                    end else begin
                        coin_cnt_d[p] = coin_cnt_q[p] - CNT_W'(1);
                    end
                end
                default: coin_state_d[p] = COIN_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            tog_q           <= 1'b0;
            primed_q        <= 1'b0;
            p1_key_q        <= '0;
            p2_key_q        <= '0;
            svc_key_q       <= '0;
            joy0_q          <= '0;
            joy1_q          <= '0;
            p1_dir_q        <= '0;
            p2_dir_q        <= '0;
            p1_btn_q        <= '0;
            p2_btn_q        <= '0;
            p1_start_q      <= 1'b0;
            p2_start_q      <= 1'b0;
            p1_pause_q      <= 1'b0;
            p2_pause_q      <= 1'b0;
            service_q       <= '0;
            coin_src_q      <= '0;
            coin_src_prev_q <= '0;
            coin_state_q[0] <= COIN_IDLE;
            coin_state_q[1] <= COIN_IDLE;
            coin_cnt_q[0]   <= '0;
            coin_cnt_q[1]   <= '0;
        end else begin
            tog_q           <= tog_d;
            primed_q        <= primed_d;
            p1_key_q        <= p1_key_d;
            p2_key_q        <= p2_key_d;
            svc_key_q       <= svc_key_d;
            joy0_q          <= joy0_d;
            joy1_q          <= joy1_d;
            p1_dir_q        <= p1_dir_d;
            p2_dir_q        <= p2_dir_d;
            p1_btn_q        <= p1_btn_d;
            p2_btn_q        <= p2_btn_d;
            p1_start_q      <= p1_start_d;
            p2_start_q      <= p2_start_d;
            p1_pause_q      <= p1_pause_d;
            p2_pause_q      <= p2_pause_d;
            service_q       <= service_d;
            coin_src_q      <= coin_src_d;
            coin_src_prev_q <= coin_src_prev_d;
            coin_state_q[0] <= coin_state_d[0];
            coin_state_q[1] <= coin_state_d[1];
            coin_cnt_q[0]   <= coin_cnt_d[0];
            coin_cnt_q[1]   <= coin_cnt_d[1];
        end
    end

    assign p1_dir     = p1_dir_q;
    assign p2_dir     = p2_dir_q;
    assign p1_buttons = p1_btn_q;
    assign p2_buttons = p2_btn_q;
    assign p1_start   = p1_start_q;
    assign p2_start   = p2_start_q;
    assign p1_pause   = p1_pause_q;
    assign p2_pause   = p2_pause_q;
    assign service    = service_q;
    assign p1_coin    = (coin_state_q[0] == COIN_PULSE);
    assign p2_coin    = (coin_state_q[1] == COIN_PULSE);

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Player-input front end for the arcade core. Sits between the HPS keyboard/joystick outputs and the `Main` joystick inputs, in the clk_sys domain. Merges PS/2 key events with MiSTer joystick words and registers all controls. Also cancels opposing directions and stretches coin presses into fixed-length pulses that the game CPU can always sample.

## Interface
Parameters:
- COIN_CYCLES, 4800000: coin output pulse length in clk_sys cycles. Legal range is 1 to 2^23-1.

Ports:
- clk_sys  in  1: system clock. All logic is on its rising edge.
- RESET  in  1: asynchronous, active-high reset.
- ps2_key  in  11: [10] event toggle, [9] pressed, [8] extended (ignored), [7:0] scan code.
- joystick_0  in  11: player 1. [0] R, [1] L, [2] D, [3] U, [4..6] B1..B3, [7] start, [8] coin, [9] pause.
- joystick_1  in  11: player 2, same layout.
- p1_dir, p2_dir  out  4: {up, down, left, right}, after opposing-direction cancel.
- p1_buttons, p2_buttons  out  3: {B3, B2, B1}.
- p1_start, p2_start, p1_pause, p2_pause  out  1: level controls.
- p1_coin, p2_coin  out  1: stretched coin pulses.
- service  out  2: {service2, service1}.

## Operation
- **Key map** (scan code -> key latch):
  - Player 1: 75 up, 72 down, 6B left, 74 right, 14 B1, 11 B2, 29 B3, 16 start, 2E coin, 4D pause.
  - Player 2: 2D up, 2B down, 23 left, 34 right, 1C B1, 1B B2, 15 B3, 1E start, 36 coin. Player 2 pause comes from the joystick only.
  - Service: 46 service1, 45 service2.
  - Unmapped codes have no effect.
- **Event detect:**
  - Register `tog_q` holds the last seen ps2_key[10].
  - An event occurs on an edge where ps2_key[10] differs from `tog_q` and `primed` = 1. On an event, the matching key latch takes ps2_key[9].
  - `primed` is 0 after reset. The first edge after reset loads `tog_q` and sets `primed` without generating an event, so a stale toggle cannot create a phantom press.
- **Joystick:** joystick_0/1 are registered into `joy_q` on every edge.
- **Combine stage:** each control = key latch OR `joy_q` bit.
  - Opposing-direction cancel: if up and down are both 1, both outputs are 0. Same rule for left and right.
  - The combine stage drives all outputs from registers.
- **Coin FSM** (one per player), states IDLE and PULSE:
  - `src` = combined coin; `src_q` = its value on the previous edge.
  - IDLE -> PULSE on `src` AND NOT `src_q`. Counter loads COIN_CYCLES-1 and coin output goes to 1.
  - PULSE: counter decrements each edge. When the counter is 0, the state goes to IDLE and coin output goes to 0.
  - Rising edges of `src` during PULSE are ignored.
  - `src` held high past the pulse does not extend or retrigger it. A new pulse needs a new rising edge seen while in IDLE.
- Counter width is 23 bits, unsigned, and never wraps; it stops at 0.

## Timing
- Reset: every output, key latch, `joy_q`, `tog_q`, `primed`, `src_q` and counter is 0; coin FSMs are in IDLE. Reset asserted mid-pulse aborts the pulse immediately (async).
- Latency, keyboard: ps2_key toggles before edge k; the latch updates at edge k; the output updates at edge k+1.
- Latency, joystick: joystick changes before edge k; `joy_q` updates at edge k; the output updates at edge k+1. Both paths have 2-edge latency.
- Coin: combined source rises at edge k+1 (visible after k+1); p*_coin is 1 after edge k+2. It stays 1 for exactly COIN_CYCLES edges.
- Simultaneous key release and joystick press of the same control: the output stays 1 (OR).
- A new ps2 event every cycle is legal; each event is applied in order.

## Test plan
- **Reset/prime:** hold ps2_key[10]=1 through reset, release reset -> no latch changes and all outputs stay 0 for 10 cycles.
- **Key path:** toggle ps2_key with code 75 and pressed=1 -> p1_dir=1000 two edges later. Toggle with code 75 and pressed=0 -> p1_dir=0000 two edges later. Code 0x5A -> no change.
- **SOCD:** key_up held plus joystick_0[2]=1 -> p1_dir[3:2]=00. Release the joystick -> p1_dir=1000.
- **Coin, COIN_CYCLES=4:**
  - joystick_1[8] high for 1 cycle -> p2_coin high for exactly 4 cycles.
  - Hold the input for 20 cycles -> a single 4-cycle pulse.
  - Re-pulse the input during a pulse -> no extension.
- **Coin after release:** pulse ends, toggle the source 0 -> 1 -> new 4-cycle pulse starting 2 edges after the rise.
- **Mid-pulse reset:** assert RESET on the 2nd pulse cycle -> p1_coin=0 immediately. After release, no pulse occurs until a new rising edge.
